// File: rtl/hmmm_mem_responder.sv
// hmmm_mem_responder: unified instr/data store with a loader front-end that holds the core in reset until the image is in.
`timescale 1ns/1ps
module hmmm_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 15,
  parameter int CNT_W  = 8
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic              mem_write,
  output logic [WORD_W-9:0] mem_data1,
  inout  wire  [7:0]        mem_data2,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              ld_overflow,
  output logic [CNT_W-1:0]  wr_count
);
  typedef enum logic [1:0] {LOAD, RUN, ERR} state_t;
  state_t state, state_s;
  logic [ADDR_W-1:0] ptr, ptr_s;
  logic [CNT_W-1:0] cnt, cnt_s;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] word;
  logic hs, wr;
  assign word = mem[adr];
  assign hs = ld_valid & ld_ready;
  assign wr = (state == RUN) & mem_write & ~reset;
  assign ld_ready = (state == LOAD) & ~reset;
  assign cpu_reset = reset | (state != RUN);
  assign loaded = state == RUN;
  assign ld_overflow = state == ERR;
  assign wr_count = cnt;
  assign mem_data1 = word[WORD_W-1:8];
  assign mem_data2 = (state == RUN && !mem_write) ? word[7:0] : 'z;
  // ph2 samples inputs into the master half; ph1 makes it visible for the next cycle
  always_ff @(posedge ph2) begin
    state_s <= reset ? LOAD : hs ? (ld_last ? RUN : (&ptr ? ERR : LOAD)) : state;
    ptr_s <= reset ? '0 : hs ? ptr + ADDR_W'(1) : ptr;
    cnt_s <= reset ? '0 : (wr && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge ph1) begin
    state <= state_s;
    ptr <= ptr_s;
    cnt <= cnt_s;
  end
  // contents survive reset so a reload can be partial
  always_ff @(posedge ph2) begin
    if (hs) mem[ptr] <= ld_data;
    if (wr) mem[adr][7:0] <= mem_data2;
  end
endmodule

// File: tb/tb_hmmm_mem_responder.sv
// tb_hmmm_mem_responder: table-driven loader vectors plus a read-back scoreboard for the memory responder.
`timescale 1ns/1ps
module tb_hmmm_mem_responder;
  logic ph1 = 0, ph2 = 0, reset = 0, mem_write = 0, ld_valid = 0, ld_last = 0;
  logic [7:0] adr = 0;
  logic [14:0] ld_data = 0;
  logic drv_en = 0;
  logic [7:0] drv = 0;
  wire [7:0] mem_data2;
  logic [6:0] mem_data1;
  logic ld_ready, cpu_reset, loaded, ld_overflow;
  logic [7:0] wr_count;
  int checks = 0, errors = 0;

  typedef struct {logic v; logic [14:0] d; logic l;} ld_vec_t;
  typedef struct {logic [7:0] a; logic [14:0] w;} sb_t;
  ld_vec_t ld_tab[5];
  sb_t sb[$];

  assign mem_data2 = drv_en ? drv : 8'bz;

  hmmm_mem_responder dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .adr(adr), .mem_write(mem_write),
    .mem_data1(mem_data1), .mem_data2(mem_data2), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .cpu_reset(cpu_reset),
    .loaded(loaded), .ld_overflow(ld_overflow), .wr_count(wr_count)
  );

  initial begin
    #5;
    forever begin
      ph1 = 1; #2 ph1 = 0; #3 ph2 = 1; #2 ph2 = 0; #3;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // start of a cycle: state has just transferred, inputs may change
  task automatic go();
    @(posedge ph1);
    #1;
  endtask

  task automatic do_reset();
    go();
    reset = 1; ld_valid = 0; ld_last = 0; mem_write = 0; drv_en = 0;
    #3;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ld_ready", ld_ready, 0);
    go();
    reset = 0;
  endtask

  task automatic read_back();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      go();
      adr = e.a; mem_write = 0; drv_en = 0; ld_valid = 0;
      #3;
      chk("rd_data1", mem_data1, e.w[14:8]);
      chk("rd_data2", mem_data2, e.w[7:0]);
    end
  endtask

  function automatic logic [14:0] w1(int i);
    return i == 16 ? 15'h1234 : 15'((i << 8) | (i * 7 + 3));
  endfunction

  function automatic logic [14:0] w4(int i, int salt);
    return 15'((i * 113) ^ salt);
  endfunction

  initial begin
    int ptr;
    ld_tab[0] = '{1'b1, 15'h1234, 1'b0};
    ld_tab[1] = '{1'b0, 15'h2222, 1'b0};
    ld_tab[2] = '{1'b1, 15'h0456, 1'b0};
    ld_tab[3] = '{1'b0, 15'h2222, 1'b1};
    ld_tab[4] = '{1'b1, 15'h7FFF, 1'b1};

    // power-up reset
    go();
    reset = 1;
    #3;
    chk("init_cpu_reset", cpu_reset, 1);
    chk("init_ld_ready", ld_ready, 0);
    go();
    #3;
    chk("init_loaded", loaded, 0);
    chk("init_overflow", ld_overflow, 0);
    chk("init_wr_count", wr_count, 0);

    // first image fills 0..19 so later reloads can be checked for retention
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      go();
      ld_valid = 1; ld_data = w1(i); ld_last = (i == 19);
      #3;
      chk("p1_ld_ready", ld_ready, 1);
    end
    go();
    ld_valid = 0; ld_last = 0;
    #3;
    chk("p1_loaded", loaded, 1);

    // reload three words with gaps in ld_valid
    do_reset();
    #3;
    chk("rl_cpu_reset", cpu_reset, 1);
    chk("rl_loaded", loaded, 0);
    ptr = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) go();
      ld_valid = ld_tab[i].v; ld_data = ld_tab[i].d; ld_last = ld_tab[i].l;
      if (i == 0) #3; else #3;
      chk("tab_ld_ready", ld_ready, 1);
      if (ld_tab[i].v) begin
        sb.push_back('{8'(ptr), ld_tab[i].d});
        ptr++;
      end
    end
    go();
    ld_valid = 1; ld_data = 15'h2AAA; ld_last = 0;
    #3;
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_loaded", loaded, 1);
    chk("run_ld_ready", ld_ready, 0);
    go();
    #3;
    chk("run_ld_ready2", ld_ready, 0);
    ld_valid = 0;
    sb.push_back('{8'h03, w1(3)});
    sb.push_back('{8'h10, 15'h1234});
    read_back();

    // processor byte write: bench owns the bus
    go();
    adr = 8'h10; mem_write = 1; drv_en = 1; drv = 8'hA5;
    #3;
    chk("wr_bus", mem_data2, 8'hA5);
    chk("wr_count_pre", wr_count, 0);
    go();
    mem_write = 0; drv_en = 0;
    #3;
    chk("wr_rd_data1", mem_data1, 7'h12);
    chk("wr_rd_data2", mem_data2, 8'hA5);
    chk("wr_count_1", wr_count, 1);

    // reset mid-RUN
    go();
    reset = 1;
    #3;
    chk("mid_cpu_reset", cpu_reset, 1);
    chk("mid_ld_ready", ld_ready, 0);
    go();
    reset = 0; ld_valid = 1; ld_data = 15'h0ABC; ld_last = 1;
    #3;
    chk("mid_load_state", ld_ready, 1);
    chk("mid_loaded", loaded, 0);
    chk("mid_wr_count", wr_count, 0);
    chk("mid_data1", mem_data1, 7'h12);
    go();
    ld_valid = 0; ld_last = 0;
    #3;
    chk("mid_reloaded", loaded, 1);
    sb.push_back('{8'h00, 15'h0ABC});
    sb.push_back('{8'h10, 15'h12A5});
    read_back();

    // write counter saturation
    for (int i = 0; i < 300; i++) begin
      go();
      adr = 8'h20; mem_write = 1; drv_en = 1; drv = 8'(i);
      #3;
      chk("sat_wr_count", wr_count, (i > 255) ? 255 : i);
    end
    go();
    mem_write = 0; drv_en = 0;
    #3;
    chk("sat_final", wr_count, 255);
    chk("sat_data2", mem_data2, 8'h2B);

    // overflow: 256 words without ld_last
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i > 0) go();
      ld_valid = 1; ld_data = w4(i, 16'h3C3C); ld_last = 0;
      #3;
      chk("ovf_ld_ready", ld_ready, 1);
      if (i == 1 || i == 128 || i == 255) sb.push_back('{8'(i), w4(i, 16'h3C3C)});
    end
    for (int k = 0; k < 3; k++) begin
      go();
      #3;
      chk("ovf_flag", ld_overflow, 1);
      chk("ovf_cpu_reset", cpu_reset, 1);
      chk("ovf_ld_ready", ld_ready, 0);
      chk("ovf_loaded", loaded, 0);
    end
    do_reset();
    ld_valid = 1; ld_data = 15'h0001; ld_last = 1;
    #3;
    chk("ovf_clear", ld_overflow, 0);
    sb.push_front('{8'h00, 15'h0001});
    go();
    ld_valid = 0; ld_last = 0;
    #3;
    chk("ovf_reload", loaded, 1);
    read_back();

    // last word exactly at the final address is not an overflow
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i > 0) go();
      ld_valid = 1; ld_data = w4(i, 16'h0F0F); ld_last = (i == 255);
      #3;
      if (i == 0 || i == 255) sb.push_back('{8'(i), w4(i, 16'h0F0F)});
    end
    go();
    ld_valid = 0; ld_last = 0;
    #3;
    chk("edge_loaded", loaded, 1);
    chk("edge_overflow", ld_overflow, 0);
    chk("edge_cpu_reset", cpu_reset, 0);
    read_back();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
